// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC update scheduler.
// Optional macro DAC_SYNC_LDAC_EN adds the LDAC state.
package dac_pkg;

  localparam int CH_W     = 2;
  localparam int MODE_W   = 2;
  localparam int SAMPLE_W = 12;
  localparam int CMD_W    = CH_W + MODE_W + SAMPLE_W;

  localparam logic [MODE_W-1:0] CMD_MODE = 2'b01;

  localparam int DEF_GAP_CYCLES  = 2;
  localparam int DEF_ACK_TIMEOUT = 8;

`ifdef DAC_SYNC_LDAC_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_ACK, S_WAIT_DONE, S_GUARD, S_LDAC
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_ACK, S_WAIT_DONE, S_GUARD
  } state_t;
`endif

  function automatic logic [CMD_W-1:0] make_cmd(input logic [CH_W-1:0]     ch,
                                                 input logic [SAMPLE_W-1:0] sample);
    return {ch, CMD_MODE, sample};
  endfunction

endpackage

// File: rtl/dac_update_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester.
// The pointer moves only when the grant is actually taken.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [1:0]   grant_idx
);

  logic [1:0] ptr_reg;
  logic [2:0] cand;
  logic       found;

  always_comb begin
    grant     = '0;
    grant_idx = 2'd0;
    found     = 1'b0;
    cand      = 3'd0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr_reg} + 3'(off);
      if (cand >= 3'(N)) cand = cand - 3'(N);
      if (!found && req[cand[1:0]]) begin
        found             = 1'b1;
        grant[cand[1:0]]  = 1'b1;
        grant_idx         = cand[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_reg <= 2'd0;
    end else if (advance && found) begin
      ptr_reg <= (grant_idx == 2'(N-1)) ? 2'd0 : grant_idx + 2'd1;
    end
  end

endmodule

// File: rtl/dac_update_scheduler.sv
// Schedules per-channel DAC sample updates onto one SPI DAC master.
// Define DAC_SYNC_LDAC_EN to add ldac_n, pulsed low after a burst of updates.
module dac_update_scheduler
  import dac_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_CH-1:0]          ch_wr,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_data,
  input  logic                       ovr_clr,
  output logic                       spi_start,
  output logic [CMD_W-1:0]           spi_data,
  input  logic                       spi_busy,
  output logic [NUM_CH-1:0]          pending,
  output logic [NUM_CH-1:0]          overrun,
  output logic                       timeout_err,
  output logic                       idle
`ifdef DAC_SYNC_LDAC_EN
  ,
  output logic                       ldac_n
`endif
);

  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  state_t                     state_reg, state_next;
  logic [CNT_W-1:0]           cnt_reg;
  logic [CMD_W-1:0]           spi_data_reg;
  logic                       timeout_reg;
  logic                       grant_fire;
  logic                       timeout_hit;
  logic [NUM_CH-1:0]          grant;
  logic [1:0]                 grant_idx;
  logic [NUM_CH*SAMPLE_W-1:0] hold_flat;
  logic [SAMPLE_W-1:0]        win_sample;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk       (clk),
    .resetn    (resetn),
    .req       (pending),
    .advance   (grant_fire),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [SAMPLE_W-1:0] hold_reg;
    logic                pend_reg;
    logic                ovr_reg;
    logic                take;

    assign take = grant_fire & grant[gi];

    // A write racing its own grant is a fresh request, not a coalesce.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        hold_reg <= '0;
        pend_reg <= 1'b0;
        ovr_reg  <= 1'b0;
      end else begin
        if (ch_wr[gi]) hold_reg <= ch_data[gi*SAMPLE_W +: SAMPLE_W];
        if (ch_wr[gi])  pend_reg <= 1'b1;
        else if (take)  pend_reg <= 1'b0;
        if (ch_wr[gi] && pend_reg && !take) ovr_reg <= 1'b1;
        else if (ovr_clr)                   ovr_reg <= 1'b0;
      end
    end

    assign pending[gi]                          = pend_reg;
    assign overrun[gi]                          = ovr_reg;
    assign hold_flat[gi*SAMPLE_W +: SAMPLE_W]   = hold_reg;
  end

  always_comb begin
    win_sample = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) win_sample = hold_flat[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  // cnt_reg restarts on every state change; START counts toward the ack window.
  always_comb begin
    state_next  = state_reg;
    grant_fire  = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_reg)
      S_IDLE: begin
        if (|pending) begin
          grant_fire = 1'b1;
          state_next = S_START;
        end
      end
      S_START:     state_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (spi_busy) begin
          state_next = S_WAIT_DONE;
        end else if (cnt_reg == CNT_W'(ACK_TIMEOUT - 2)) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_WAIT_DONE: if (!spi_busy) state_next = S_GUARD;
      S_GUARD: begin
        if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
`ifdef DAC_SYNC_LDAC_EN
          state_next = (|pending) ? S_IDLE : S_LDAC;
`else
          state_next = S_IDLE;
`endif
        end
      end
`ifdef DAC_SYNC_LDAC_EN
      S_LDAC:      if (cnt_reg == CNT_W'(1)) state_next = S_IDLE;
`endif
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      spi_data_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= (state_next != state_reg) ? '0 : cnt_reg + CNT_W'(1);
      if (grant_fire)  spi_data_reg <= make_cmd(grant_idx, win_sample);
      if (timeout_hit) timeout_reg  <= 1'b1;
    end
  end

  assign spi_start   = (state_reg == S_START);
  assign spi_data    = spi_data_reg;
  assign timeout_err = timeout_reg;
  assign idle        = (state_reg == S_IDLE) && !(|pending);
`ifdef DAC_SYNC_LDAC_EN
  assign ldac_n      = (state_reg != S_LDAC);
`endif

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Scoreboard bench for dac_update_scheduler with a behavioural SPI DAC master.
// Build with DAC_SYNC_LDAC_EN defined to also exercise ldac_n.
module tb_dac_update_scheduler;

  localparam int NUM_CH   = 4;
  localparam int CLK_DIV  = 3;
  localparam int BUSY_LEN = 16 * CLK_DIV;
  localparam int GAP      = 2;
`ifdef DAC_SYNC_LDAC_EN
  localparam int IDLE_LAG = GAP + 3;
`else
  localparam int IDLE_LAG = GAP + 1;
`endif

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic [NUM_CH-1:0]    ch_wr = '0;
  logic [NUM_CH*12-1:0] ch_data = '0;
  logic                 ovr_clr = 1'b0;
  logic                 spi_start;
  logic [15:0]          spi_data;
  logic                 spi_busy;
  logic [NUM_CH-1:0]    pending;
  logic [NUM_CH-1:0]    overrun;
  logic                 timeout_err;
  logic                 idle;
`ifdef DAC_SYNC_LDAC_EN
  logic                 ldac_n;
`endif

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  int          start_cnt, fall_cnt, last_start_cyc, fall_cyc;
  logic        busy_prev;
  logic [15:0] cur_word;
  logic        busy_en = 1'b1;
  logic        gap_chk = 1'b0;
  int          ldac_low_cnt, ldac_first_cyc, ldac_starts;
  int          wr_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_update_scheduler #(.NUM_CH(NUM_CH), .GAP_CYCLES(GAP), .ACK_TIMEOUT(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ch_wr       (ch_wr),
    .ch_data     (ch_data),
    .ovr_clr     (ovr_clr),
    .spi_start   (spi_start),
    .spi_data    (spi_data),
    .spi_busy    (spi_busy),
    .pending     (pending),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .idle        (idle)
`ifdef DAC_SYNC_LDAC_EN
    ,
    .ldac_n      (ldac_n)
`endif
  );

  // SPI DAC master model: busy one clock after start, for BUSY_LEN clocks
  int bcnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spi_busy <= 1'b0;
      bcnt     <= 0;
    end else if (spi_start && busy_en) begin
      spi_busy <= 1'b1;
      bcnt     <= BUSY_LEN;
    end else if (spi_busy) begin
      if (bcnt == 1) spi_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: pops the scoreboard on every spi_start.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      start_cnt = 0; fall_cnt = 0; busy_prev = 1'b0;
      ldac_low_cnt = 0; ldac_first_cyc = -1; ldac_starts = -1;
    end else begin
      if (spi_start) begin
        if (gap_chk && fall_cnt > 0) chk("guard_gap_ge3", ((cyc - fall_cyc) >= GAP + 1), 1);
        start_cnt++;
        last_start_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_start actual=%0h required=none", spi_data);
        end else begin
          cur_word = exp_q.pop_front();
          chk("spi_data", spi_data, cur_word);
          $display("xfer %0d: cycle %0d word %04h", start_cnt, cyc, spi_data);
        end
      end
      if (busy_prev && !spi_busy) begin
        fall_cnt++;
        fall_cyc = cyc;
        chk("spi_data_stable", spi_data, cur_word);
      end
      busy_prev = spi_busy;
`ifdef DAC_SYNC_LDAC_EN
      if (!ldac_n) begin
        if (ldac_low_cnt == 0) begin
          ldac_first_cyc = cyc;
          ldac_starts    = start_cnt;
        end
        ldac_low_cnt++;
      end
`endif
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic write_mask(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*12-1:0] data);
    @(posedge clk); #1;
    ch_wr   = mask;
    ch_data = data;
    wr_cyc  = cyc;
    @(posedge clk); #1;
    ch_wr   = '0;
  endtask

  task automatic write1(input int ch, input logic [11:0] d);
    logic [NUM_CH*12-1:0] v;
    logic [NUM_CH-1:0]    m;
    v = '0; m = '0;
    v[ch*12 +: 12] = d;
    m[ch] = 1'b1;
    write_mask(m, v);
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (start_cnt < target && n < 600) begin @(negedge clk); #1; n++; end
    chk("starts_seen", start_cnt, target);
  endtask

  task automatic wait_falls(input int target);
    int n = 0;
    while (fall_cnt < target && n < 600) begin @(negedge clk); #1; n++; end
    chk("busy_falls_seen", fall_cnt, target);
  endtask

  task automatic goto_cycle(input int k);
    while (cyc < k) begin @(negedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    // Reset values, sampled while reset is held
    #13;
    chk("rst_spi_start", spi_start, 0);
    chk("rst_spi_data", spi_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_idle", idle, 1);
`ifdef DAC_SYNC_LDAC_EN
    chk("rst_ldac_n", ldac_n, 1);
`endif
    #10 resetn = 1'b1;

    // Single write: latency, command word, idle after guard
    goto_cycle(9);
    exp_q.push_back(16'h9ABC);
    write1(2, 12'hABC);
    $display("write ch2 at cycle %0d", wr_cyc);
    wait_starts(1);
    chk("start_latency", last_start_cyc, wr_cyc + 2);
    wait_falls(1);
    goto_cycle(fall_cyc + IDLE_LAG - 1);
    chk("idle_during_guard", idle, 0);
    goto_cycle(fall_cyc + IDLE_LAG);
    chk("idle_after_guard", idle, 1);

    // Four simultaneous writes: round-robin order 0,1,2,3
    reset_dut();
    exp_q.push_back(16'h1100);
    exp_q.push_back(16'h5211);
    exp_q.push_back(16'h9322);
    exp_q.push_back(16'hD433);
    gap_chk = 1'b1;
    write_mask(4'b1111, {12'h433, 12'h322, 12'h211, 12'h100});
    wait_starts(4);
    wait_falls(4);
    gap_chk = 1'b0;
    goto_cycle(fall_cyc + IDLE_LAG);
    chk("burst_idle", idle, 1);

    // Coalesced writes on ch1 during a ch0 transfer
    reset_dut();
    exp_q.push_back(16'h10AA);
    exp_q.push_back(16'h5222);
    write1(0, 12'h0AA);
    wait_starts(1);
    s = last_start_cyc;
    write1(1, 12'h111);
    write1(1, 12'h222);
    goto_cycle(s + 3);
    chk("coalesce_pending", pending, 4'b0010);
    chk("coalesce_overrun", overrun, 4'b0010);
    wait_starts(2);
    wait_falls(2);
    goto_cycle(fall_cyc + IDLE_LAG);
    chk("overrun_sticky", overrun, 4'b0010);
    @(posedge clk); #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    chk("overrun_cleared", overrun, 4'b0000);

    // Lost handshake: spi_busy never rises
    reset_dut();
    busy_en = 1'b0;
    exp_q.push_back(16'hD777);
    write1(3, 12'h777);
    wait_starts(1);
    s = last_start_cyc;
    goto_cycle(s + 7);
    chk("timeout_not_yet", timeout_err, 0);
    goto_cycle(s + 8);
    chk("timeout_err", timeout_err, 1);
    chk("timeout_idle", idle, 1);
    chk("timeout_pending", pending, 0);
    goto_cycle(s + 20);
    chk("timeout_no_retry", start_cnt, 1);
    busy_en = 1'b1;

    // Asynchronous reset mid-transfer, then normal operation
    reset_dut();
    exp_q.push_back(16'h55A5);
    write1(1, 12'h5A5);
    wait_starts(1);
    goto_cycle(last_start_cyc + 3);
    write1(0, 12'h0F0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_spi_start", spi_start, 0);
    chk("arst_spi_data", spi_data, 0);
    chk("arst_pending", pending, 0);
    chk("arst_timeout", timeout_err, 0);
    chk("arst_idle", idle, 1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    exp_q.push_back(16'h9123);
    write1(2, 12'h123);
    wait_starts(1);
    chk("post_reset_latency", last_start_cyc, wr_cyc + 2);
    wait_falls(1);

`ifdef DAC_SYNC_LDAC_EN
    // Synchronous LDAC after the last transfer of a burst
    reset_dut();
    exp_q.push_back(16'h1001);
    exp_q.push_back(16'hD00F);
    write_mask(4'b1001, {12'h00F, 12'h000, 12'h000, 12'h001});
    wait_starts(2);
    wait_falls(2);
    goto_cycle(fall_cyc + GAP + 6);
    chk("ldac_low_clocks", ldac_low_cnt, 2);
    chk("ldac_after_second", ldac_starts, 2);
    chk("ldac_first_cycle", ldac_first_cyc, fall_cyc + GAP + 1);
`endif

    goto_cycle(cyc + 3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
